hazard_ctrl: RTL

- Pipeline sequencer for the 5-stage MIPS core (IF, ID, EX, MEM, WB).
- Keeps an internal scoreboard that shadows the in-flight destination registers.
- Detects RAW hazards and branch redirects for the instruction in ID, then drives the pipeline's stall, bubble and flush controls.
- Sits beside the ctrl unit; its outputs gate pc PCWr and the ifid/idex register enables.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/hazard_ctrl_if.sv | 38 +++
 rtl/hazard_sb.sv | 54 +++++
 rtl/hazard_ctrl.sv | 87 ++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - scoreboard entry type, bypass codes and match helpers for the hazard unit
package mips_pkg;

  localparam int RW    = 5;
  localparam int DEPTH = 3;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } sb_entry_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;
  localparam logic [1:0] FWD_BUS  = 2'b11;

  function automatic logic sb_match(input sb_entry_t e, input logic [RW-1:0] r);
    return e.v && (e.rd == r) && (r != '0);
  endfunction

  // Entry 0 is the EX-stage producer, so older entries map to later bypass points.
  function automatic logic [1:0] fwd_code(input int idx);
    case (idx)
      0:       return FWD_MEM;
      1:       return FWD_WB;
      default: return FWD_BUS;
    endcase
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID-stage request and pipeline-control bundle of the hazard unit
interface hazard_ctrl_if #(
  parameter int RW    = 5,
  parameter int CNT_W = 16
) ();

  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          id_GPRWr;
  logic [RW-1:0] id_rd;
  logic          id_MTR;
  logic          id_branch;
  logic          br_taken;

  logic             PCWr;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_GPRWr, id_rd, id_MTR,
           id_branch, br_taken,
    input  PCWr, ifid_hold, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_GPRWr, id_rd, id_MTR,
           id_branch, br_taken,
    output PCWr, ifid_hold, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_cnt
  );

endinterface

// File: rtl/hazard_sb.sv
// rtl/hazard_sb.sv - in-flight destination scoreboard (EX, MEM, WB) with youngest-first match
module hazard_sb #(
  parameter int DEPTH = 3,
  parameter int RW    = 5
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  logic [RW-1:0] push_rd,
  input  logic          push_ld,
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  output logic          hit_rs,
  output logic          hit_rt,
  output logic          ld_rs,
  output logic          ld_rt,
  output logic [1:0]    sel_rs,
  output logic [1:0]    sel_rt
);
  import mips_pkg::*;

  sb_entry_t sb [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) sb[i] <= '0;
    end else begin
      sb[0] <= '{v: push, rd: push_rd, ld: push_ld};
      for (int i = 1; i < DEPTH; i++) sb[i] <= sb[i-1];
    end
  end

  // Walk oldest to youngest so the youngest producer's code is left standing.
  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    sel_rs = FWD_NONE;
    sel_rt = FWD_NONE;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (sb_match(sb[i], rs)) begin
        hit_rs = 1'b1;
        sel_rs = fwd_code(i);
      end
      if (sb_match(sb[i], rt)) begin
        hit_rt = 1'b1;
        sel_rt = fwd_code(i);
      end
    end
  end

  assign ld_rs = sb_match(sb[0], rs) & sb[0].ld;
  assign ld_rt = sb_match(sb[0], rt) & sb[0].ld;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RAW/branch hazard sequencer for the 5-stage MIPS pipeline
// Optional HAZARD_FWD_EN: stall on load-use only and register bypass selects.
module hazard_ctrl #(
  parameter int DEPTH = 3,
  parameter int RW    = 5,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         clr,
  hazard_ctrl_if.slave bus
);
  import mips_pkg::*;

  logic             hit_rs, hit_rt, ld_rs, ld_rt;
  logic [1:0]       sel_rs, sel_rt;
  logic             haz, stall, push, kill_q, br_flush;
  logic [CNT_W-1:0] cnt_q;

  hazard_sb #(.DEPTH(DEPTH), .RW(RW)) u_sb (
    .clk     (clk),
    .clr     (clr),
    .push    (push),
    .push_rd (bus.id_rd),
    .push_ld (bus.id_MTR),
    .rs      (bus.id_rs),
    .rt      (bus.id_rt),
    .hit_rs  (hit_rs),
    .hit_rt  (hit_rt),
    .ld_rs   (ld_rs),
    .ld_rt   (ld_rt),
    .sel_rs  (sel_rs),
    .sel_rt  (sel_rt)
  );

`ifdef HAZARD_FWD_EN
  assign haz = bus.id_valid & ((bus.id_use_rs & ld_rs) | (bus.id_use_rt & ld_rt));
`else
  assign haz = bus.id_valid & ((bus.id_use_rs & hit_rs) | (bus.id_use_rt & hit_rt));
`endif

  assign stall    = haz & ~clr;
  assign br_flush = bus.id_valid & bus.id_branch & bus.br_taken;
  assign push     = bus.id_valid & bus.id_GPRWr & (bus.id_rd != '0) & ~stall & ~kill_q;

  assign bus.PCWr        = ~clr & ~stall;
  assign bus.ifid_hold   = stall;
  assign bus.idex_bubble = clr | stall;
  assign bus.ifid_flush  = clr | (~stall & br_flush);
  assign bus.stall_cnt   = cnt_q;

  // The slot behind a flush is a wrong-path fetch and must never claim a register.
  always_ff @(posedge clk) begin
    if (clr) kill_q <= 1'b1;
    else     kill_q <= bus.ifid_flush;
  end

  always_ff @(posedge clk) begin
    if (clr)                  cnt_q <= '0;
    else if (stall && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  end

`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_a_q, fwd_b_q;
  logic       unused_hit;

  always_ff @(posedge clk) begin
    if (clr || stall || !bus.id_valid) begin
      fwd_a_q <= FWD_NONE;
      fwd_b_q <= FWD_NONE;
    end else begin
      fwd_a_q <= bus.id_use_rs ? sel_rs : FWD_NONE;
      fwd_b_q <= bus.id_use_rt ? sel_rt : FWD_NONE;
    end
  end

  assign bus.fwd_a  = fwd_a_q;
  assign bus.fwd_b  = fwd_b_q;
  assign unused_hit = hit_rs ^ hit_rt;
`else
  logic unused_fwd;

  assign bus.fwd_a  = FWD_NONE;
  assign bus.fwd_b  = FWD_NONE;
  assign unused_fwd = ^{sel_rs, sel_rt, ld_rs, ld_rt};
`endif

endmodule
